// File: rtl/fft_pkg.sv
// Shared constants, twiddle tables and state encoding for the 16-point FFT.
package fft_pkg;

  localparam int N       = 16;
  localparam int LOG2N   = 4;
  localparam int IN_W    = 12;
  localparam int OUT_W   = 16;
  localparam int TW_FRAC = 14;
  localparam int TW_W    = 16;

  typedef logic signed [TW_W-1:0] tw_t;

  localparam tw_t COS_TAB [8] = '{
    16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
    16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137
  };

  localparam tw_t SIN_TAB [8] = '{
    16'sd0,      16'sd6270,   16'sd11585,  16'sd15137,
    16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev4(
    input logic [LOG2N-1:0] n
  );
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: t = W*b rounded from Q1.14, then
// saturating a+t and a-t.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  input  tw_t                 w_cos,
  input  tw_t                 w_sin,
  output logic signed [W-1:0] x_r,
  output logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_r,
  output logic signed [W-1:0] y_i
);

  localparam int PW = W + TW_W + 1;
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (TW_FRAC - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (W - 1) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  function automatic logic signed [W-1:0] sat(
    input logic signed [PW-1:0] v
  );
    if (v > MAXV) return W'(MAXV);
    if (v < MINV) return W'(MINV);
    return W'(v);
  endfunction

  logic signed [PW-1:0] p_r;
  logic signed [PW-1:0] p_i;
  logic signed [PW-1:0] t_r;
  logic signed [PW-1:0] t_i;

  // W = cos - j*sin, so (cos - j sin)(br + j bi)
  assign p_r = PW'(w_cos) * PW'(b_r)
             + PW'(w_sin) * PW'(b_i) + RND;
  assign p_i = PW'(w_cos) * PW'(b_i)
             - PW'(w_sin) * PW'(b_r) + RND;

  assign t_r = p_r >>> TW_FRAC;
  assign t_i = p_i >>> TW_FRAC;

  assign x_r = sat(PW'(a_r) + t_r);
  assign x_i = sat(PW'(a_i) + t_i);
  assign y_r = sat(PW'(a_r) - t_r);
  assign y_i = sat(PW'(a_i) - t_i);

endmodule

// File: rtl/fft_core.sv
// 16-point in-place radix-2 DIT FFT: load in bit-reversed order,
// one butterfly per cycle, stream bins out in natural order.
module fft_core #(
  parameter int IN_W  = fft_pkg::IN_W,
  parameter int OUT_W = fft_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din_r,
  input  logic [IN_W-1:0]  din_i,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout_r,
  output logic [OUT_W-1:0] dout_i
);

  import fft_pkg::*;

  localparam int BF_LAST = (N / 2) * LOG2N - 1;

  state_t                  state;
  logic [LOG2N-1:0]        samp_cnt;
  logic [LOG2N-1:0]        out_cnt;
  logic [LOG2N:0]          bf_cnt;

  logic signed [OUT_W-1:0] mem_r [N];
  logic signed [OUT_W-1:0] mem_i [N];

  logic                    accept;
  logic signed [OUT_W-1:0] sx_r;
  logic signed [OUT_W-1:0] sx_i;

  logic [1:0]              stg;
  logic [2:0]              jj;
  logic [3:0]              h;
  logic [3:0]              pos;
  logic [3:0]              top;
  logic [3:0]              bot;
  logic [2:0]              tw;

  logic signed [OUT_W-1:0] x_r;
  logic signed [OUT_W-1:0] x_i;
  logic signed [OUT_W-1:0] y_r;
  logic signed [OUT_W-1:0] y_i;

  assign accept = in_valid &&
                  (state == IDLE || state == LOAD);

  assign sx_r = {{(OUT_W-IN_W){din_r[IN_W-1]}}, din_r};
  assign sx_i = {{(OUT_W-IN_W){din_i[IN_W-1]}}, din_i};

  // Butterfly address generation from the stage/index counter
  assign stg = bf_cnt[4:3];
  assign jj  = bf_cnt[2:0];
  assign h   = 4'd1 << stg;
  assign pos = {1'b0, jj} & (h - 4'd1);
  assign top = (({1'b0, jj} >> stg) << (3'(stg) + 3'd1)) | pos;
  assign bot = top | h;
  assign tw  = 3'(pos << (2'd3 - stg));

  fft_butterfly #(
    .W (OUT_W)
  ) u_bfly (
    .a_r   (mem_r[top]),
    .a_i   (mem_i[top]),
    .b_r   (mem_r[bot]),
    .b_i   (mem_i[bot]),
    .w_cos (COS_TAB[tw]),
    .w_sin (SIN_TAB[tw]),
    .x_r   (x_r),
    .x_i   (x_i),
    .y_r   (y_r),
    .y_i   (y_i)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (accept) begin
        mem_r[bitrev4(samp_cnt)] <= sx_r;
        mem_i[bitrev4(samp_cnt)] <= sx_i;
      end else if (state == COMPUTE) begin
        mem_r[top] <= x_r;
        mem_i[top] <= x_i;
        mem_r[bot] <= y_r;
        mem_i[bot] <= y_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      bf_cnt    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            samp_cnt <= 4'd1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'(N - 1)) begin
              bf_cnt <= '0;
              state  <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          bf_cnt <= bf_cnt + 5'd1;
          if (bf_cnt == 5'(BF_LAST)) begin
            out_cnt <= '0;
            state   <= OUTPUT;
          end
        end
        OUTPUT: begin
          out_valid <= 1'b1;
          dout_r    <= mem_r[out_cnt];
          dout_i    <= mem_i[out_cnt];
          out_cnt   <= out_cnt + 4'd1;
          if (out_cnt == 4'(N - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_core.sv
// Directed bench for fft_core: frame table with hand-derived spectra,
// plus gapped-input and reset-in-every-phase sequences.
module tb_fft_core;

  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int NF    = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic [IN_W-1:0]  din_r;
  logic [IN_W-1:0]  din_i;
  logic             out_valid;
  logic [OUT_W-1:0] dout_r;
  logic [OUT_W-1:0] dout_i;

  always #5 clk = ~clk;

  fft_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  typedef struct {
    int xr;
    int xi;
    int er;
    int ei;
  } rec_t;

  rec_t tv [NF][16];

  int n_cmp = 0;
  int n_bad = 0;

  int rot_r [8] = '{1000, 924, 707, 383, 0, -383, -707, -924};
  int rot_i [8] = '{0, -383, -707, -924, -1000, -924, -707, -383};
  int q4_r  [4] = '{0, 1000, 0, -1000};
  int q4_i  [4] = '{1000, 0, -1000, 0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic feed(input int f, input bit gap);
    for (int n = 0; n < 16; n++) begin
      if (gap) begin
        in_valid = 1'b0;
        din_r    = 12'd5;
        din_i    = 12'd5;
        tick();
      end
      in_valid = 1'b1;
      din_r    = IN_W'(tv[f][n].xr);
      din_i    = IN_W'(tv[f][n].xi);
      tick();
    end
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
  endtask

  task automatic collect(input int f, input bit extras, input string tag);
    int first;
    int nv;
    int zbad;
    int k;
    first = -1;
    nv    = 0;
    zbad  = 0;
    for (int c = 1; c <= 49; c++) begin
      if (extras && c >= 2 && c <= 20) begin
        in_valid = c[0];
        din_r    = 12'd777;
        din_i    = -12'sd5;
      end else begin
        in_valid = 1'b0;
        din_r    = '0;
        din_i    = '0;
      end
      tick();
      if (out_valid) begin
        if (first < 0) first = c;
        k = c - first;
        if (k < 16) begin
          check($sformatf("%s bin%0d re", tag, k),
                int'($signed(dout_r)), tv[f][k].er);
          check($sformatf("%s bin%0d im", tag, k),
                int'($signed(dout_i)), tv[f][k].ei);
        end
        nv++;
      end else if (dout_r != '0 || dout_i != '0) begin
        zbad = 1;
      end
    end
    check($sformatf("%s latency", tag), first, 33);
    check($sformatf("%s valid_len", tag), nv, 16);
    check($sformatf("%s idle_zero", tag), zbad, 0);
  endtask

  initial begin
    int quiet;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    tick();
    tick();
    check("reset out_valid", int'(out_valid), 0);
    check("reset dout_r", int'(dout_r), 0);
    check("reset dout_i", int'(dout_i), 0);
    reset_n = 1'b1;

    for (int f = 0; f < NF; f++)
      for (int n = 0; n < 16; n++)
        tv[f][n] = '{0, 0, 0, 0};

    // 0: impulse
    tv[0][0].xr = 1;
    for (int n = 0; n < 16; n++) tv[0][n].er = 1;
    // 1: DC
    for (int n = 0; n < 16; n++) tv[1][n].xr = 100;
    tv[1][0].er = 1600;
    // 2: Nyquist
    for (int n = 0; n < 16; n++)
      tv[2][n].xr = (n % 2 == 0) ? 1000 : -1000;
    tv[2][8].er = 16000;
    // 3: full-scale negative DC
    for (int n = 0; n < 16; n++) tv[3][n].xr = -2048;
    tv[3][0].er = -32768;
    // 4: delayed impulse x[1]=1000 exercises every twiddle
    tv[4][1].xr = 1000;
    for (int k = 0; k < 8; k++) begin
      tv[4][k].er     = rot_r[k];
      tv[4][k].ei     = rot_i[k];
      tv[4][k + 8].er = -rot_r[k];
      tv[4][k + 8].ei = -rot_i[k];
    end
    // 5: x[4]=j*1000, spectrum repeats every 4 bins
    tv[5][4].xi = 1000;
    for (int k = 0; k < 16; k++) begin
      tv[5][k].er = q4_r[k % 4];
      tv[5][k].ei = q4_i[k % 4];
    end

    for (int f = 0; f < NF; f++) begin
      feed(f, 1'b0);
      collect(f, 1'b0, $sformatf("frame%0d", f));
    end

    feed(0, 1'b1);
    collect(0, 1'b1, "gapped");

    // reset mid-LOAD
    for (int n = 0; n < 7; n++) begin
      in_valid = 1'b1;
      din_r    = 12'd500;
      din_i    = 12'd300;
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    quiet   = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) quiet = 0;
    end
    check("rst_load quiet", quiet, 1);
    feed(1, 1'b0);
    collect(1, 1'b0, "rst_load");

    // reset mid-COMPUTE
    feed(4, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    feed(0, 1'b0);
    collect(0, 1'b0, "rst_comp");

    // reset mid-OUTPUT
    feed(2, 1'b0);
    for (int c = 0; c < 34; c++) tick();
    check("pre_rst out_valid", int'(out_valid), 1);
    reset_n = 1'b0;
    tick();
    check("rst_out out_valid", int'(out_valid), 0);
    check("rst_out dout_r", int'(dout_r), 0);
    reset_n = 1'b1;
    feed(5, 1'b0);
    collect(5, 1'b0, "rst_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_core.md
FFT_CORE -- requirements
Module: fft_core

Interface
REQ-001 SHALL have parameter IN_W, default 12, the input sample width per component (signed).
REQ-002 SHALL have parameter OUT_W, default 16, the output width per component (signed).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: din_r/din_i carry a sample this cycle.
REQ-006 SHALL have ports din_r and din_i, input, IN_W bits each: real and imaginary input sample, two's complement.
REQ-007 SHALL have port out_valid, output, 1 bit: dout_r/dout_i carry a spectrum bin this cycle.
REQ-008 SHALL have ports dout_r and dout_i, output, OUT_W bits each: real and imaginary output bin, two's complement.

Function
REQ-009 SHALL compute a 16-point forward DFT, X[k] = sum over n of x[n]·e^(-j2πkn/16), on frames of 16 accepted samples.
REQ-010 SHALL use a state machine with states IDLE, LOAD, COMPUTE and OUTPUT.
- IDLE -> LOAD on the first accepted sample.
- LOAD -> COMPUTE on the 16th accepted sample.
- COMPUTE -> OUTPUT after 32 cycles.
- OUTPUT -> IDLE after 16 cycles.
REQ-011 SHALL accept a sample only in IDLE or LOAD with in_valid=1; gaps in in_valid are allowed and stall the sample count.
REQ-012 SHALL drop in_valid samples presented in COMPUTE or OUTPUT, with no effect on the frame in progress.
REQ-013 SHALL sign-extend each accepted sample to OUT_W bits and store sample n at buffer address bitrev4(n).
REQ-014 SHALL hold the buffer as 16 complex words of OUT_W bits each, read and written in place.
REQ-015 SHALL execute in COMPUTE one radix-2 DIT butterfly per cycle: 4 stages × 8 butterflies = 32 cycles.
REQ-016 SHALL schedule each butterfly, for stage s = 0..3, h = 2^s, j = 0..7, as follows:
- pos = j mod h; top = (j div h)·2h + pos; bot = top + h.
- twiddle index = pos·(8>>s).
REQ-017 SHALL compute each butterfly as t = W·b, a' = a + t, b' = a - t.
- W is taken from Q1.14 tables, cos = {16384,15137,11585,6270,0,-6270,-11585,-15137} and sin = {0,6270,11585,15137,16384,15137,11585,6270}, with W = cos - j·sin.
REQ-018 SHALL round each complex product component by adding 2^13 and arithmetic-shifting right by 14.
REQ-019 SHALL saturate every butterfly sum and difference to [-32768, 32767], with no scaling between stages.
REQ-020 SHALL output bins in natural order k = 0..15 on 16 consecutive cycles, with out_valid=1 on each.
- The first bin is registered 33 rising edges after the edge that captured sample 15.
REQ-021 SHALL drive out_valid=0 and dout_r = dout_i = 0 whenever no bin is being presented.
REQ-022 SHALL accept the next frame's first sample on the cycle immediately after the last out_valid cycle.

Reset
REQ-023 SHALL, on reset_n=0 at a rising edge, enter IDLE and clear the sample and butterfly counters, with out_valid=0, dout_r=0 and dout_i=0.
REQ-024 SHALL leave buffer contents undefined after reset; they are never output before being overwritten.
REQ-025 SHALL, on reset in any state (mid-LOAD, mid-COMPUTE, mid-OUTPUT), abandon the frame; the next frame is processed correctly.

Structure
REQ-026 SHALL place N=16, LOG2N=4, IN_W, OUT_W, TW_FRAC=14, the cos/sin twiddle tables and the state enum in shared package fft_pkg.
REQ-027 SHALL implement the butterfly (complex multiply, rounding, saturating add/subtract) as the combinational sub-module fft_butterfly.

Verification
REQ-028 SHALL verify the impulse case: frame x[0] = (1,0), x[1..15] = (0,0) -> all 16 bins (1,0).
REQ-029 SHALL verify the DC case: all 16 samples (100,0) -> X[0] = (1600,0), X[1..15] = (0,0).
REQ-030 SHALL verify the Nyquist case: x[n] = (1000,0) for even n and (-1000,0) for odd n -> X[8] = (16000,0), all other bins (0,0).
REQ-031 SHALL verify full scale: all samples (-2048,0) -> X[0] = (-32768,0), others (0,0); out_valid is high for exactly 16 cycles, starting 33 edges after the last sample.
REQ-032 SHALL verify gapped input: the impulse frame with in_valid low every other cycle, plus extra in_valid pulses during COMPUTE -> the same result as REQ-028, with extra samples ignored.
REQ-033 SHALL verify reset recovery: 7 samples accepted, then reset_n=0 for one cycle, then the DC frame -> the result of REQ-029, with out_valid=0 until then.
